// File: rtl/ctl_pipe.sv
// ctl_pipe: multi-stage control-word pipeline register carrying a decoded
// control word from decode to execute. It adds a valid bit per stage, a
// pipeline-wide stall and flush, and a saturating bubble counter.
module ctl_pipe #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 2,
  parameter logic [WIDTH-1:0] NOP_VALUE = {WIDTH{1'b0}},
  parameter int               CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_ctl,
  input  logic             stall,
  input  logic             flush,
  input  logic             cnt_clr,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_ctl,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] bubble_cnt
);

  // Stage 0 is the youngest entry; stage DEPTH-1 drives the outputs.
  logic [DEPTH-1:0]            v_q, v_d;
  logic [DEPTH-1:0][WIDTH-1:0] c_q, c_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;

  // Next pipeline contents: flush beats stall, stall beats advance.
  always_comb begin
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    v_d = v_q;
    c_d = c_q;
    if (flush) begin
      // Flush drops the incoming word too; every stage becomes a bubble.
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        c_d[i] = NOP_VALUE;
      end
    end else if (!stall) begin
      // An invalid input never captures in_ctl, keeping the invariant
      // that an invalid stage holds NOP_VALUE.
      v_d[0] = in_valid;
      c_d[0] = in_valid ? in_ctl : NOP_VALUE;
      for (int i = 1; i < DEPTH; i++) begin
        v_d[i] = v_q[i-1];
        c_d[i] = c_q[i-1];
      end
    end
  end

  // Next bubble count: clear wins, otherwise saturating increment on a bubble.
  always_comb begin
    cnt_d = cnt_q;
    if (cnt_clr) begin
      cnt_d = '0;
    end else if (!v_q[DEPTH-1] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Pipeline stage registers with asynchronous reset to the bubble encoding.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the pre-edge value of its predecessor.
    if (rst) begin
      // NOTE: the control words are reset along with the valid bits because
      // consumers may decode out_ctl directly and must see NOP_VALUE.
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        c_q[i] <= NOP_VALUE;
      end
    end else begin
      v_q <= v_d;
      c_q <= c_d;
    end
  end

  // Bubble counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Outputs come straight from the registers.
  assign out_valid   = v_q[DEPTH-1];
  assign out_ctl     = c_q[DEPTH-1];
  assign stage_valid = v_q;
  assign bubble_cnt  = cnt_q;

endmodule

// File: doc/ctl_pipe.md
# ctl_pipe

Parametrised control-signal pipeline register for the simple pipelined core. It carries a decoded control word from decode through DEPTH register stages to the execute-side consumers, replacing single-stage fixed-field control latches. Over a plain latch it adds a per-stage valid bit, a pipeline-wide stall (hold) and flush (bubble insert), and a saturating bubble counter for performance monitoring.

## Interface
- WIDTH, 8: control word width in bits; must be ≥1.
- DEPTH, 2: number of register stages; must be ≥1.
- NOP_VALUE, {WIDTH{1'b0}}: control word held by an invalid stage, used as the bubble encoding.
- CNT_W, 16: bubble counter width.

- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_ctl carries a real instruction this cycle.
- in_ctl  in  WIDTH  control word from decode.
- stall  in  1  hold all stages this cycle.
- flush  in  1  invalidate all stages this cycle.
- cnt_clr  in  1  synchronous clear of bubble_cnt.
- out_valid  out  1  valid bit of stage DEPTH-1.
- out_ctl  out  WIDTH  control word of stage DEPTH-1.
- stage_valid  out  DEPTH  valid bit of every stage; bit 0 is the youngest stage.
- bubble_cnt  out  CNT_W  count of cycles with out_valid=0.

## Operation
- State per stage i (0..DEPTH-1): v[i] and c[i][WIDTH-1:0]. Invariant: v[i]=0 implies c[i]=NOP_VALUE.
- Per-edge priority is rst > flush > stall > advance.
- rst asserted: v[*]=0, c[*]=NOP_VALUE, bubble_cnt=0, applied immediately (asynchronous). This also applies mid-stall or mid-flush.
- flush=1: v[*] is set to 0 and c[*] to NOP_VALUE. stall and in_* are ignored, so the incoming word is dropped.
- stall=1, flush=0: every v[i] and c[i] holds and in_* is ignored. Bubbles are not collapsed; partially empty pipelines hold as they are.
- Advance (stall=0, flush=0):
  - Stage 0: v[0]=in_valid and c[0]=in_valid ? in_ctl : NOP_VALUE. An invalid input's in_ctl is never captured.
  - Stages i≥1: v[i]=v[i-1] and c[i]=c[i-1].
- Outputs come straight from registers with no combinational path from inputs: out_valid=v[DEPTH-1], out_ctl=c[DEPTH-1], stage_valid=v.
- bubble_cnt is updated each edge when not in reset:
  - cnt_clr=1: the counter is set to 0. This takes priority over the increment.
  - Otherwise, if the current out_valid=0 and bubble_cnt is below 2^CNT_W-1, the counter increments by 1.
  - The counter saturates at all-ones and never wraps.
  - Stall does not affect counting; a stalled invalid output still counts.
- DEPTH=1 degenerates to a single latch with valid/stall/flush semantics unchanged.

## Timing
- Latency: a word accepted at edge N (advance, in_valid=1) appears on out_ctl after edge N+DEPTH-1, provided no stall occurs. Each stall cycle adds one cycle. A flush before exit destroys the word.
- Throughput: one word per non-stalled cycle.
- Reset values: out_valid=0, out_ctl=NOP_VALUE, stage_valid=0, bubble_cnt=0.
- stall and flush are sampled at the same edge as in_*. Upstream must itself hold in_ctl during a stall; ctl_pipe does not buffer the dropped input.
- Simultaneous stall+flush: the flush is applied and the pipeline is empty after the edge.
- Reset deassertion must meet recovery timing to clk. The first possible capture is the first rising edge with rst low.

## Test plan
- Reset: while rst=1, drive in_valid=1, in_ctl=8'hA5 and toggle clk. Required: out_valid=0, out_ctl=8'h00, stage_valid=2'b00 throughout. Then release rst.
- Streaming: with DEPTH=2, drive words 8'h11, 8'h22, 8'h33 on consecutive edges (valid, no stall). Required: out_ctl reads 11, 22, 33 after edges 2, 3, 4, with out_valid=1 for each.
- Stall hold: load 8'h11 then 8'h22, then assert stall for 3 cycles while in_ctl=8'hFF. Required: stage_valid=2'b11, out_ctl=8'h11 for all 3 cycles. After release, 8'h22 then 8'hFF emerge; 8'hFF appears only if in_valid=1 after the stall.
- Flush priority: with a full pipeline, assert stall=1 and flush=1 together. Required after the edge: stage_valid=2'b00 and out_ctl=8'h00. The next valid input, 8'h44, appears 2 cycles later.
- Invalid input masking: advance with in_valid=0, in_ctl=8'h5A. Required: c[0]=8'h00, so out_ctl never shows 5A.
- Bubble counter: with CNT_W=4, hold in_valid=0 for 20 cycles after reset. Required: bubble_cnt saturates at 4'hF with no wrap. Pulse cnt_clr together with out_valid=0. Required: bubble_cnt=0 after that edge, then it resumes incrementing.
